wave_mixer: RTL

//  Parametrised multi-channel PCM sample player. Fetches 16-bit signed little-endian samples
//  for NUM_CH independent voices from the byte-wide DDRAM read port (ddram rd/ready handshake),

---
 rtl/wave_mixer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/wave_mixer.sv
// Multi-voice PCM sample player: fetches 16-bit LE samples per voice over a byte-wide
// read port once per sample frame, attenuates, sums with saturation and publishes the mix.
module wave_mixer #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 28,
    parameter int CLK_HZ    = 24000000,
    parameter int SAMPLE_HZ = 48000
) (
    input  logic                     I_CLK,
    input  logic                     I_RSTn,
    input  logic [NUM_CH-1:0]        I_TRIG,
    input  logic [NUM_CH-1:0]        I_STOP,
    input  logic [NUM_CH-1:0]        I_LOOP,
    input  logic [NUM_CH*ADDR_W-1:0] I_BASE_ADDR,
    input  logic [NUM_CH*ADDR_W-1:0] I_LEN,
    input  logic [NUM_CH*3-1:0]      I_VOL,
    input  logic                     I_PAUSE,
    output logic [ADDR_W-1:0]        O_ADDR,
    output logic                     O_READ,
    input  logic [7:0]               I_DATA,
    input  logic                     I_READY,
    output logic [15:0]              O_PCM,
    output logic                     O_SAMPLE_STB,
    output logic [NUM_CH-1:0]        O_ACTIVE,
    output logic                     O_OVERRUN
);

    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = 16 + $clog2(NUM_CH) + 1;

    localparam logic signed [ACC_W-1:0] PCM_MAX = 32767;
    localparam logic signed [ACC_W-1:0] PCM_MIN = -32768;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_RD_LO   = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_RD_HI   = 3'd4;
    localparam logic [2:0] S_WAIT_HI = 3'd5;
    localparam logic [2:0] S_ACC     = 3'd6;
    localparam logic [2:0] S_OUT     = 3'd7;

    logic [2:0]                    state;
    logic [DIV_W-1:0]              div_cnt;
    logic [NUM_CH-1:0]             active;
    logic [NUM_CH-1:0]             pend;
    logic [NUM_CH-1:0][ADDR_W-1:0] pos;
    logic [IDX_W-1:0]              vi;
    logic [7:0]                    lo_q;
    logic [7:0]                    hi_q;
    logic signed [ACC_W-1:0]       acc;
    logic [ADDR_W-1:0]             addr_q;
    logic [15:0]                   pcm_q;
    logic                          stb_q;
    logic                          ovr_q;

    logic                    tick;
    logic [NUM_CH-1:0]       act_apply;
    logic [IDX_W:0]          first_sel;
    logic [IDX_W:0]          next_sel;
    logic                    nxt_found;
    logic [IDX_W-1:0]        nxt_idx;
    logic [ADDR_W-1:0]       nxt_addr;
    logic [ADDR_W-1:0]       len_v;
    logic [ADDR_W:0]         pos_nx;
    logic                    wrap_v;
    logic [2:0]              vol_v;
    logic signed [ACC_W-1:0] smp_ext;
    logic signed [ACC_W-1:0] contrib;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_fin;

    // Lowest-numbered set bit at or above start, as {found, index}.
    function automatic logic [IDX_W:0] find_from(input logic [NUM_CH-1:0] act, input int start);
        logic [IDX_W:0] r;
        r = '0;
        for (int v = NUM_CH - 1; v >= 0; v--)
            if (act[v] && v >= start) r = {1'b1, IDX_W'(v)};
        return r;
    endfunction

    function automatic logic [15:0] clamp16(input logic signed [ACC_W-1:0] a);
        if (a > PCM_MAX)      return 16'h7FFF;
        else if (a < PCM_MIN) return 16'h8000;
        else                  return a[15:0];
    endfunction

    always_comb begin
        tick = !I_PAUSE && (div_cnt == DIV_W'(DIV - 1));
        for (int v = 0; v < NUM_CH; v++)
            act_apply[v] = pend[v] ? (I_LEN[v*ADDR_W +: ADDR_W] >= ADDR_W'(2)) : active[v];
        // Voices stopped this very cycle must not be scheduled for a fetch.
        first_sel = find_from(act_apply & ~I_STOP, 0);
        next_sel  = find_from(active & ~I_STOP, int'(vi) + 1);
        nxt_found = (state == S_APPLY) ? first_sel[IDX_W] : next_sel[IDX_W];
        nxt_idx   = (state == S_APPLY) ? first_sel[IDX_W-1:0] : next_sel[IDX_W-1:0];
        nxt_addr  = I_BASE_ADDR[nxt_idx*ADDR_W +: ADDR_W]
                  + (((state == S_APPLY) && pend[nxt_idx]) ? ADDR_W'(0) : pos[nxt_idx]);
        len_v     = I_LEN[vi*ADDR_W +: ADDR_W];
        vol_v     = I_VOL[vi*3 +: 3];
        pos_nx    = {1'b0, pos[vi]} + (ADDR_W+1)'(2);
        wrap_v    = (pos_nx + (ADDR_W+1)'(2)) > {1'b0, len_v};
        smp_ext   = {{(ACC_W-16){hi_q[7]}}, hi_q, lo_q};
        contrib   = smp_ext >>> vol_v;
        acc_sum   = acc + contrib;
        acc_fin   = ((state == S_ACC) && active[vi]) ? acc_sum : acc;
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            active  <= '0;
            pend    <= '0;
            pos     <= '0;
            vi      <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            acc     <= '0;
            addr_q  <= '0;
            pcm_q   <= '0;
            stb_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            if (!I_PAUSE) div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick && state != S_IDLE) ovr_q <= 1'b1;
            pend <= (((state == S_APPLY) ? {NUM_CH{1'b0}} : pend) | I_TRIG) & ~I_STOP;

            case (state)
                S_IDLE:    if (tick) state <= S_APPLY;
                S_APPLY: begin
                    active <= act_apply;
                    for (int v = 0; v < NUM_CH; v++)
                        if (pend[v]) pos[v] <= '0;
                end
                S_RD_LO:   state <= S_WAIT_LO;
                S_WAIT_LO: if (I_READY) begin
                    lo_q   <= I_DATA;
                    addr_q <= addr_q + 1'b1;
                    state  <= S_RD_HI;
                end
                S_RD_HI:   state <= S_WAIT_HI;
                S_WAIT_HI: if (I_READY) begin
                    hi_q  <= I_DATA;
                    state <= S_ACC;
                end
                S_ACC: if (active[vi]) begin
                    acc <= acc_sum;
                    if (!wrap_v)        pos[vi] <= pos_nx[ADDR_W-1:0];
                    else if (I_LOOP[vi]) pos[vi] <= '0;
                    else begin
                        pos[vi]    <= pos_nx[ADDR_W-1:0];
                        active[vi] <= 1'b0;
                    end
                end
                S_OUT:     state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase

            // Leaving APPLY or ACC: fetch the next live voice, or publish the frame.
            if (state == S_APPLY || state == S_ACC) begin
                if (nxt_found) begin
                    vi     <= nxt_idx;
                    addr_q <= nxt_addr;
                    state  <= S_RD_LO;
                end else begin
                    pcm_q <= clamp16(acc_fin);
                    stb_q <= 1'b1;
                    acc   <= '0;
                    state <= S_OUT;
                end
            end

            for (int v = 0; v < NUM_CH; v++)
                if (I_STOP[v]) active[v] <= 1'b0;
        end
    end

    assign O_READ       = (state == S_RD_LO) || (state == S_RD_HI);
    assign O_ADDR       = addr_q;
    assign O_PCM        = pcm_q;
    assign O_SAMPLE_STB = stb_q;
    assign O_ACTIVE     = active;
    assign O_OVERRUN    = ovr_q;

endmodule
